// File: rtl/rom_dl_sequencer.sv
// Packs the data_io byte stream into 16-bit words and issues toggle-handshake writes to two SDRAM ports.
// Optional ROM_DL_CHECKSUM_EN adds a wrapping byte checksum; otherwise checksum is tied to zero.
module rom_dl_sequencer #(
  parameter logic [7:0]  ROM_INDEX = 8'h00,
  parameter logic [24:0] GFX_BASE  = 25'h10000,
  parameter int          AW        = 23
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          user_reset,
  input  logic          ioctl_downl,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          port1_req,
  input  logic          port1_ack,
  output logic [AW-1:0] port1_a,
  output logic [1:0]    port1_ds,
  output logic [15:0]   port1_d,
  output logic          port1_we,
  output logic          port2_req,
  input  logic          port2_ack,
  output logic [AW-1:0] port2_a,
  output logic [1:0]    port2_ds,
  output logic [15:0]   port2_d,
  output logic          port2_we,
  output logic          rom_loaded,
  output logic          core_reset,
  output logic          dl_overflow,
  output logic [15:0]   checksum
);
  localparam logic [23:0] GFX_WORD = GFX_BASE[24:1];

  typedef struct packed {
    logic          region;
    logic [AW-1:0] a;
    logic [1:0]    ds;
    logic [15:0]   d;
  } entry_t;

  typedef enum logic [1:0] {X_IDLE, X_ISSUE, X_WAIT} xstate_t;
  typedef enum logic [1:0] {D_IDLE, D_FLUSH, D_DONE} dstate_t;

  function automatic entry_t mk_entry(input logic [23:0] word, input logic [1:0] ds,
                                      input logic [15:0] d);
    entry_t e;
    e.region = (word >= GFX_WORD);
    e.a      = e.region ? AW'(word - GFX_WORD) : AW'(word);
    e.ds     = ds;
    e.d      = d;
    return e;
  endfunction

  logic        wr_q, downl_q;
  logic        pend_valid_q, pend_valid_d;
  logic [23:0] pend_addr_q, pend_addr_d;
  logic [7:0]  pend_lo_q, pend_lo_d;
  entry_t      fifo_q [2];
  entry_t      fifo_d [2];
  logic [1:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  xstate_t     x_q, x_d;
  dstate_t     dl_q, dl_d;
  logic        p1_req_q, p1_we_q, p2_req_q, p2_we_q;
  logic [AW-1:0] p1_a_q, p2_a_q;
  logic [1:0]  p1_ds_q, p2_ds_q;
  logic [15:0] p1_d_q, p2_d_q;
  logic        loaded_q, core_rst_q;

  // Byte acceptance and end-of-download qualification
  logic        idx_ok, accept, dl_end, same_word;
  logic [23:0] word;
  assign idx_ok    = (ioctl_index == ROM_INDEX);
  assign accept    = ioctl_wr & ~wr_q & ioctl_downl & idx_ok;
  assign dl_end    = downl_q & ~ioctl_downl & idx_ok;
  assign word      = ioctl_addr[24:1];
  assign same_word = pend_valid_q && (pend_addr_q == word);

  entry_t head, ent_p, ent_n;
  logic   push_p, push_n, issue, pop, acked, set_loaded;
  assign head  = fifo_q[0];
  assign ent_p = mk_entry(pend_addr_q, 2'b01, {8'h00, pend_lo_q});

  // Packing: a stale pending half-word is always pushed ahead of the new word
  always_comb begin
    push_p       = 1'b0;
    push_n       = 1'b0;
    ent_n        = '0;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_lo_d    = pend_lo_q;
    if (accept) begin
      if (pend_valid_q && !same_word) push_p = 1'b1;
      if (!ioctl_addr[0]) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = word;
        pend_lo_d    = ioctl_dout;
      end else if (same_word) begin
        push_n       = 1'b1;
        ent_n        = mk_entry(word, 2'b11, {ioctl_dout, pend_lo_q});
        pend_valid_d = 1'b0;
      end else begin
        push_n       = 1'b1;
        ent_n        = mk_entry(word, 2'b10, {ioctl_dout, 8'h00});
        pend_valid_d = 1'b0;
      end
    end else if (dl_end && pend_valid_q) begin
      push_p       = 1'b1;
      pend_valid_d = 1'b0;
    end
  end

  // Two-entry FIFO: pop shifts first, then up to two ordered pushes append
  always_comb begin
    fifo_d = fifo_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (pop) begin
      fifo_d[0] = fifo_q[1];
      cnt_d     = cnt_q - 2'd1;
    end
    if (push_p) begin
      if (cnt_d == 2'd2) ovf_d = 1'b1;
      else begin
        fifo_d[cnt_d[0]] = ent_p;
        cnt_d            = cnt_d + 2'd1;
      end
    end
    if (push_n) begin
      if (cnt_d == 2'd2) ovf_d = 1'b1;
      else begin
        fifo_d[cnt_d[0]] = ent_n;
        cnt_d            = cnt_d + 2'd1;
      end
    end
  end

  // Transfer FSM: state register
  always_ff @(posedge clk_sys) begin
    if (reset) x_q <= X_IDLE;
    else       x_q <= x_d;
  end

  // Transfer FSM: next state
  always_comb begin
    x_d = x_q;
    case (x_q)
      X_IDLE:  if (cnt_q != 2'd0) x_d = X_ISSUE;
      X_ISSUE: x_d = X_WAIT;
      X_WAIT:  if (acked) x_d = (cnt_d != 2'd0) ? X_ISSUE : X_IDLE;
      default: x_d = X_IDLE;
    endcase
  end

  // Transfer FSM: outputs. Ack is only looked at in WAIT, so stale ack edges after reset are ignored.
  always_comb begin
    acked = head.region ? (port2_ack == p2_req_q) : (port1_ack == p1_req_q);
    issue = (x_q == X_ISSUE);
    pop   = (x_q == X_WAIT) && acked;
  end

  // Download FSM: state register
  always_ff @(posedge clk_sys) begin
    if (reset) dl_q <= D_IDLE;
    else       dl_q <= dl_d;
  end

  // Download FSM: next state
  always_comb begin
    dl_d = dl_q;
    case (dl_q)
      D_IDLE:  if (dl_end) dl_d = D_FLUSH;
      D_FLUSH: if (cnt_q == 2'd0 && x_q == X_IDLE) dl_d = D_DONE;
      D_DONE:  dl_d = D_IDLE;
      default: dl_d = D_IDLE;
    endcase
  end

  // Download FSM: outputs
  always_comb begin
    set_loaded = (dl_q == D_DONE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_q         <= 1'b0;
      downl_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_lo_q    <= '0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      loaded_q     <= 1'b0;
      core_rst_q   <= 1'b1;
    end else begin
      wr_q         <= ioctl_wr;
      downl_q      <= ioctl_downl;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_lo_q    <= pend_lo_d;
      fifo_q       <= fifo_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      loaded_q     <= loaded_q | set_loaded;
      core_rst_q   <= user_reset | ~loaded_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      p1_req_q <= 1'b0; p1_we_q <= 1'b0; p1_a_q <= '0; p1_ds_q <= '0; p1_d_q <= '0;
      p2_req_q <= 1'b0; p2_we_q <= 1'b0; p2_a_q <= '0; p2_ds_q <= '0; p2_d_q <= '0;
    end else begin
      if (issue && !head.region) begin
        p1_req_q <= ~p1_req_q; p1_we_q <= 1'b1;
        p1_a_q <= head.a; p1_ds_q <= head.ds; p1_d_q <= head.d;
      end
      if (issue && head.region) begin
        p2_req_q <= ~p2_req_q; p2_we_q <= 1'b1;
        p2_a_q <= head.a; p2_ds_q <= head.ds; p2_d_q <= head.d;
      end
      if (pop && !head.region) p1_we_q <= 1'b0;
      if (pop && head.region)  p2_we_q <= 1'b0;
    end
  end

`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0] csum_q;
  always_ff @(posedge clk_sys) begin
    if (reset)                         csum_q <= '0;
    else if (ioctl_downl && !downl_q)  csum_q <= '0;
    else if (accept && dl_q != D_DONE) csum_q <= csum_q + {8'h00, ioctl_dout};
  end
  assign checksum = csum_q;
`else
  assign checksum = 16'h0000;
`endif

  assign port1_req   = p1_req_q;
  assign port1_we    = p1_we_q;
  assign port1_a     = p1_a_q;
  assign port1_ds    = p1_ds_q;
  assign port1_d     = p1_d_q;
  assign port2_req   = p2_req_q;
  assign port2_we    = p2_we_q;
  assign port2_a     = p2_a_q;
  assign port2_ds    = p2_ds_q;
  assign port2_d     = p2_d_q;
  assign rom_loaded  = loaded_q;
  assign core_reset  = core_rst_q;
  assign dl_overflow = ovf_q;
endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Directed bench for rom_dl_sequencer: vector table of single-word downloads plus multi-cycle corner sequences.
module tb_rom_dl_sequencer;
  localparam logic [24:0] GFX = 25'h10000;

  logic        clk = 1'b0;
  logic        reset = 1'b1, user_reset = 1'b0;
  logic        ioctl_downl = 1'b0, ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'h00, ioctl_dout = 8'h00;
  logic [24:0] ioctl_addr = '0;
  logic        port1_req, port1_we, port2_req, port2_we;
  logic        port1_ack = 1'b0, port2_ack = 1'b0;
  logic [22:0] port1_a, port2_a;
  logic [1:0]  port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d, checksum;
  logic        rom_loaded, core_reset, dl_overflow;

  rom_dl_sequencer dut (
    .clk_sys(clk), .reset(reset), .user_reset(user_reset),
    .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_d(port1_d), .port1_we(port1_we),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d), .port2_we(port2_we),
    .rom_loaded(rom_loaded), .core_reset(core_reset),
    .dl_overflow(dl_overflow), .checksum(checksum)
  );

  // Clock / reset timing
  always #5 clk = ~clk;

  typedef struct packed {
    logic        p2;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [24:0] a0;
    logic [7:0]  b0;
    bit          two;
    logic [24:0] a1;
    logic [7:0]  b1;
    wr_t         exp;
  } vec_t;

  wr_t exp_q[$];
  int  total = 0, bad = 0;
  int  n_wr1 = 0, n_wr2 = 0;
  int  ack_dly = 3;
  int  c1 = 0, c2 = 0;
  logic last1 = 1'b0, last2 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic wr_t mkw(input logic p2, input logic [22:0] a, input logic [1:0] ds,
                              input logic [15:0] d);
    wr_t w;
    w.p2 = p2; w.a = a; w.ds = ds; w.d = d;
    return w;
  endfunction

  task automatic check_wr(input logic p2, input logic [22:0] a, input logic [1:0] ds,
                          input logic [15:0] d, input logic we);
    wr_t e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_write: port2=%0d a=%h ds=%b d=%h", p2, a, ds, d);
    end else begin
      e = exp_q.pop_front();
      chk("wr_port", {31'd0, p2}, {31'd0, e.p2});
      chk("wr_a", {9'd0, a}, {9'd0, e.a});
      chk("wr_ds", {30'd0, ds}, {30'd0, e.ds});
      chk("wr_d", {16'd0, d}, {16'd0, e.d});
      chk("wr_we", {31'd0, we}, 32'd1);
    end
  endtask

  // Scoreboard: every req toggle is one write, compared against the expected queue
  always @(negedge clk) begin
    if (reset) begin
      last1 = 1'b0; last2 = 1'b0;
    end else begin
      if (port1_req !== last1) begin
        last1 = port1_req; n_wr1++;
        check_wr(1'b0, port1_a, port1_ds, port1_d, port1_we);
      end
      if (port2_req !== last2) begin
        last2 = port2_req; n_wr2++;
        check_wr(1'b1, port2_a, port2_ds, port2_d, port2_we);
      end
    end
  end

  // SDRAM model: answers each request after ack_dly cycles
  always @(negedge clk) begin
    if (reset) begin
      port1_ack = 1'b0; port2_ack = 1'b0; c1 = 0; c2 = 0;
    end else begin
      if (port1_ack != port1_req) begin
        if (c1 >= ack_dly) begin port1_ack = port1_req; c1 = 0; end else c1++;
      end
      if (port2_ack != port2_req) begin
        if (c2 >= ack_dly) begin port2_ack = port2_req; c2 = 0; end else c2++;
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dl_start(input logic [7:0] idx);
    ioctl_index = idx; ioctl_downl = 1'b1;
    tick(2);
  endtask

  task automatic put(input logic [24:0] a, input logic [7:0] b);
    ioctl_addr = a; ioctl_dout = b; ioctl_wr = 1'b1;
    tick(2);
    ioctl_wr = 1'b0;
    tick(1);
  endtask

  task automatic dl_stop();
    ioctl_downl = 1'b0;
    tick(1);
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || port1_we || port2_we) && k < budget) begin
      tick(1); k++;
    end
    total++;
    if (k >= budget) begin
      bad++;
      $display("FAIL %s_drain_timeout: pending=%0d we1=%b we2=%b", name, exp_q.size(), port1_we, port2_we);
      exp_q.delete();
    end
    tick(6);
  endtask

  logic [15:0] exp_csum;
  vec_t vt [6];

  initial begin
`ifdef ROM_DL_CHECKSUM_EN
    exp_csum = 16'h0200;
`else
    exp_csum = 16'h0000;
`endif
    vt[0] = '{25'h0,        8'h11, 1'b1, 25'h1,       8'h22, mkw(1'b0, 23'h0,    2'b11, 16'h2211)};
    vt[1] = '{GFX + 25'd5,  8'hAB, 1'b0, 25'h0,       8'h00, mkw(1'b1, 23'h2,    2'b10, 16'hAB00)};
    vt[2] = '{25'h6,        8'h5C, 1'b0, 25'h0,       8'h00, mkw(1'b0, 23'h3,    2'b01, 16'h005C)};
    vt[3] = '{GFX,          8'h01, 1'b1, GFX + 25'd1, 8'h02, mkw(1'b1, 23'h0,    2'b11, 16'h0201)};
    vt[4] = '{GFX - 25'd1,  8'h7E, 1'b0, 25'h0,       8'h00, mkw(1'b0, 23'h7FFF, 2'b10, 16'h7E00)};
    vt[5] = '{25'h20000,    8'h33, 1'b1, 25'h20001,   8'h44, mkw(1'b1, 23'h8000, 2'b11, 16'h4433)};

    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_req1", {31'd0, port1_req}, 32'd0);
    chk("rst_we1", {31'd0, port1_we}, 32'd0);
    chk("rst_a1", {9'd0, port1_a}, 32'd0);
    chk("rst_ds2", {30'd0, port2_ds}, 32'd0);
    chk("rst_d2", {16'd0, port2_d}, 32'd0);
    chk("rst_req2", {31'd0, port2_req}, 32'd0);
    chk("rst_rom_loaded", {31'd0, rom_loaded}, 32'd0);
    chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("rst_overflow", {31'd0, dl_overflow}, 32'd0);
    chk("rst_checksum", {16'd0, checksum}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      int w;
      w = n_wr1 + n_wr2;
      dl_start(8'h00);
      exp_q.push_back(vt[i].exp);
      put(vt[i].a0, vt[i].b0);
      if (vt[i].two) put(vt[i].a1, vt[i].b1);
      chk("vec_core_reset_mid", {31'd0, core_reset}, (i == 0) ? 32'd1 : 32'd0);
      chk("vec_rom_loaded_mid", {31'd0, rom_loaded}, (i == 0) ? 32'd0 : 32'd1);
      dl_stop();
      drain("vec", 300);
      chk("vec_wr_count", n_wr1 + n_wr2 - w, 32'd1);
      chk("vec_rom_loaded", {31'd0, rom_loaded}, 32'd1);
      chk("vec_core_reset", {31'd0, core_reset}, 32'd0);
    end

    begin : even_only
      int w;
      w = n_wr1;
      dl_start(8'h00);
      exp_q.push_back(mkw(1'b0, 23'h2, 2'b01, 16'h00B4));
      exp_q.push_back(mkw(1'b0, 23'h4, 2'b01, 16'h00B8));
      put(25'h4, 8'hB4);
      put(25'h8, 8'hB8);
      dl_stop();
      drain("even_only", 300);
      chk("even_only_count", n_wr1 - w, 32'd2);
    end

    begin : double_push
      int w;
      w = n_wr1;
      dl_start(8'h00);
      exp_q.push_back(mkw(1'b0, 23'h2, 2'b01, 16'h0012));
      exp_q.push_back(mkw(1'b0, 23'h4, 2'b10, 16'h3400));
      put(25'h4, 8'h12);
      put(25'h9, 8'h34);
      dl_stop();
      drain("double_push", 300);
      chk("double_push_count", n_wr1 - w, 32'd2);
      chk("double_push_no_ovf", {31'd0, dl_overflow}, 32'd0);
    end

    begin : wrong_index
      int w;
      w = n_wr1 + n_wr2;
      dl_start(8'h01);
      put(25'h10, 8'h99);
      put(25'h11, 8'h98);
      dl_stop();
      tick(15);
      chk("wrong_index_no_write", n_wr1 + n_wr2 - w, 32'd0);
    end

    begin : csum
      dl_start(8'h00);
      exp_q.push_back(mkw(1'b0, 23'h80, 2'b11, 16'hFFFF));
      exp_q.push_back(mkw(1'b0, 23'h81, 2'b01, 16'h0002));
      put(25'h100, 8'hFF);
      put(25'h101, 8'hFF);
      put(25'h102, 8'h02);
      dl_stop();
      drain("csum", 300);
      chk("checksum", {16'd0, checksum}, {16'd0, exp_csum});
    end

    begin : overflow
      int w;
      w = n_wr1;
      ack_dly = 50;
      dl_start(8'h00);
      exp_q.push_back(mkw(1'b0, 23'h0, 2'b11, 16'h6160));
      exp_q.push_back(mkw(1'b0, 23'h1, 2'b11, 16'h6362));
      for (int k = 0; k < 6; k++) put(25'(k), 8'(8'h60 + k));
      dl_stop();
      drain("overflow", 400);
      chk("overflow_flag", {31'd0, dl_overflow}, 32'd1);
      chk("overflow_count", n_wr1 - w, 32'd2);
      ack_dly = 3;
    end

    user_reset = 1'b1;
    tick(2);
    chk("user_reset_core_reset", {31'd0, core_reset}, 32'd1);
    user_reset = 1'b0;
    tick(2);
    chk("user_reset_release", {31'd0, core_reset}, 32'd0);
    chk("user_reset_rom_loaded", {31'd0, rom_loaded}, 32'd1);

    begin : reset_in_wait
      int w, k;
      ack_dly = 50;
      dl_start(8'h00);
      exp_q.push_back(mkw(1'b0, 23'h0, 2'b11, 16'hBBAA));
      put(25'h0, 8'hAA);
      put(25'h1, 8'hBB);
      put(25'h2, 8'hCC);
      put(25'h3, 8'hDD);
      k = 0;
      while (!port1_we && k < 50) begin tick(1); k++; end
      chk("reset_wait_reached", {31'd0, port1_we}, 32'd1);
      reset = 1'b1; ioctl_downl = 1'b0;
      tick(2);
      reset = 1'b0;
      exp_q.delete();
      tick(1);
      chk("reset_wait_we", {31'd0, port1_we}, 32'd0);
      chk("reset_wait_req", {31'd0, port1_req}, 32'd0);
      chk("reset_wait_rom_loaded", {31'd0, rom_loaded}, 32'd0);
      chk("reset_wait_core_reset", {31'd0, core_reset}, 32'd1);
      chk("reset_wait_overflow", {31'd0, dl_overflow}, 32'd0);
      w = n_wr1 + n_wr2;
      tick(20);
      chk("reset_wait_fifo_empty", n_wr1 + n_wr2 - w, 32'd0);
      ack_dly = 3;
      dl_start(8'h00);
      exp_q.push_back(mkw(1'b0, 23'h20, 2'b11, 16'h6655));
      put(25'h40, 8'h55);
      put(25'h41, 8'h66);
      dl_stop();
      drain("after_reset", 300);
      chk("after_reset_count", n_wr1 + n_wr2 - w, 32'd1);
      chk("after_reset_rom_loaded", {31'd0, rom_loaded}, 32'd1);
      chk("after_reset_core_reset", {31'd0, core_reset}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, elapsed %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $finish;
  end
endmodule
